oldland_dbus_sram: RTL and testbench
====================================

Name: oldland_dbus_sram

Overview:
- Data-bus responder (target) for the data bus driven by the CPU memory stage.
- Decodes a word-aligned address window and services byte-, half- and word-lane reads and writes into an on-chip word-wide SRAM.
- Inserts a programmable number of wait states.
- Returns a one-cycle ack, or an error for out-of-window or illegal byte-lane requests.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of window; must be aligned to window size
ADDR_BITS, 10, word-address bits; window = 4*2^ADDR_BITS bytes, array = 2^ADDR_BITS x 32
WAIT_STATES, 1, extra cycles between acceptance and response (0..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset; asynchronous, active-low
d_access  in  1  request valid; initiator holds it high until it samples d_ack or d_error
d_addr  in  32  word-aligned byte address; bits [1:0] ignored
d_wr_en  in  1  1 = write, 0 = read
d_bytesel  in  4  byte-lane enables, lane n = bits [8n+7:8n]
d_wr_val  in  32  lane-positioned write data
d_data  out  32  lane-positioned read data, valid in the d_ack cycle
d_ack  out  1  one-cycle successful-completion pulse
d_error  out  1  one-cycle failed-completion pulse

Behaviour:
- Reset (async assert, sync release): state IDLE, d_ack=0, d_error=0, d_data=0, wait counter=0, captured request cleared. SRAM contents are not reset. Reset mid-transaction abandons it: no write, no response.
- States:
  - IDLE: on a clk edge with d_access=1, capture addr/wr_en/bytesel/wr_val. Load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: decrement counter each cycle; on reaching 0 go to ACCESS.
  - ACCESS: one cycle; performs the array operation and decode result. Go to RESP.
  - RESP: d_ack or d_error registered high for exactly this one cycle. Next edge returns to IDLE.
- Latency: acceptance edge E0 → response visible in the cycle after edge E0+WAIT_STATES+2. With WAIT_STATES=0, the response is visible 2 cycles after E0.
- Back-to-back: the initiator deasserts d_access at the edge ending RESP. The responder is in IDLE in the next cycle, so d_access=1 there is a new request. No transaction is ever accepted in RESP.
- Inputs are sampled only at acceptance. Changes to any input, including d_access dropping, during WAIT/ACCESS/RESP are ignored. The captured transaction completes and still pulses a response.
- Decode error if any of:
  - (addr & ~(4*2^ADDR_BITS-1)) != BASE_ADDR
  - bytesel not in {1111, 0011, 1100, 0001, 0010, 0100, 1000}
- On error: no array write, d_error=1, d_ack=0, d_data=0.
- Write (legal): only lanes with bytesel=1 are updated at word index addr[ADDR_BITS+1:2]; other lanes retain their value. d_data=0 in RESP.
- Read (legal): synchronous array read in ACCESS. d_data = full stored word, all lanes, unmasked (the initiator shifts). d_data holds its value until the next response cycle, then is overwritten.
- d_ack and d_error are never high simultaneously and never high for more than one consecutive cycle.
- Top and bottom words of the window are valid; the word at BASE_ADDR + 4*2^ADDR_BITS errors. Address wrap is not modulo; out-of-window always errors.

Test Plan:
- Reset, WAIT_STATES=1: word write 0xDEADBEEF to BASE+0x10 (bytesel 1111), then read BASE+0x10 → d_ack 3 cycles after each acceptance edge; read d_data=0xDEADBEEF; d_error never high.
- Byte merge: write 0x11223344 to BASE+0x0, then bytesel 0100 with d_wr_val=0x00AA0000, then bytesel 0011 with 0x00005566 → readback 0x11AA5566.
- Errors: read at BASE+4*2^ADDR_BITS, and write with bytesel 0101 → d_error one cycle, d_ack=0, d_data=0; subsequent read of the targeted word shows it unchanged.
- Timing sweep, WAIT_STATES=0 and 3: back-to-back reads with d_access held and re-asserted the cycle after the response → each d_ack exactly WAIT_STATES+2 cycles after its acceptance edge; no lost or duplicated transactions.
- Input stability: change d_addr/d_wr_val and drop d_access during WAIT → the original captured write completes with d_ack; memory reflects the original values.
- Async reset asserted during WAIT of a write → d_ack/d_error stay 0, the word is unchanged on readback after release, and the FSM accepts a new request on the first edge after deassertion.

Source files
------------

// File: rtl/oldland_dbus_sram.sv
`default_nettype none
// ============================================================================
// Module  : oldland_dbus_sram
// Purpose : Data-bus target that exposes a word-wide on-chip SRAM in an
//           aligned address window. It supports byte, half-word and word lane
//           accesses, inserts WAIT_STATES programmable wait cycles, and returns
//           either a one-cycle ack or a one-cycle error.
// Ports   : clk        - system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           d_access   - request valid, held by the initiator until response
//           d_addr     - byte address, bits [1:0] ignored
//           d_wr_en    - 1 = write, 0 = read
//           d_bytesel  - byte-lane enables
//           d_wr_val   - lane-positioned write data
//           d_data     - read data, valid in the ack cycle
//           d_ack      - successful-completion pulse
//           d_error    - failed-completion pulse
// Revision: 1.0 - initial release
// ============================================================================
module oldland_dbus_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_access,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error
);

    localparam logic [31:0] c_WIN_MASK = ~((32'd4 << ADDR_BITS) - 32'd1);
    localparam logic [3:0]  c_WAIT     = 4'(WAIT_STATES);

    // DECODE registers the window/lane check one cycle after acceptance so the
    // comparison never sits on the bus-input path; it also accounts for the
    // fixed two-cycle minimum response latency.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_wr;
    logic [3:0]  r_bs;
    logic [31:0] r_wval;
    logic        r_err;

    logic [31:0] r_mem [2**ADDR_BITS];

    logic                 w_win_ok;
    logic                 w_bs_ok;
    logic [ADDR_BITS-1:0] w_idx;

    assign w_win_ok = ((r_addr & c_WIN_MASK) == BASE_ADDR);
    assign w_idx    = r_addr[ADDR_BITS+1:2];

    // Only naturally aligned byte, half-word and word lane patterns are legal.
    always_comb begin
        w_bs_ok = 1'b0;
        case (r_bs)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_bs_ok = 1'b1;
            default:                            w_bs_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (d_access) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = (c_WAIT != 4'd0) ? ST_WAIT : ST_ACCESS;
            ST_WAIT:   if (r_cnt == 4'd1) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wr    <= 1'b0;
            r_bs    <= 4'd0;
            r_wval  <= 32'd0;
            r_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_error <= 1'b0;
            d_data  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            d_ack   <= 1'b0;
            d_error <= 1'b0;

            // Inputs are captured once; later changes are ignored.
            if (r_state == ST_IDLE && d_access) begin
                r_addr <= d_addr;
                r_wr   <= d_wr_en;
                r_bs   <= d_bytesel;
                r_wval <= d_wr_val;
                r_cnt  <= c_WAIT;
            end

            if (r_state == ST_DECODE) begin
                r_err <= !(w_win_ok && w_bs_ok);
            end

            if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Response flags and data become visible in the RESP cycle; d_data
            // then holds until the next response overwrites it.
            if (r_state == ST_ACCESS) begin
                d_ack   <= !r_err;
                d_error <= r_err;
                d_data  <= (!r_err && !r_wr) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Array contents are deliberately not reset. An async reset forces the FSM
    // out of ACCESS, so an abandoned transaction never writes.
    always_ff @(posedge clk) begin
        if (r_state == ST_ACCESS && !r_err && r_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (r_bs[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wval[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oldland_dbus_sram.sv
`default_nettype none
// ============================================================================
// Module  : tb_oldland_dbus_sram
// Purpose : Self-checking bench for oldland_dbus_sram. Three instances with
//           WAIT_STATES = 1, 0 and 3 share the clock and reset; each has its
//           own bus signals. Drivers push the expected response into a
//           scoreboard queue and a monitor pops and compares on every ack or
//           error, including the acceptance-to-response latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oldland_dbus_sram;

    localparam logic [31:0] c_BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        acc   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [3:0]  bs    [3];
    logic [31:0] wval  [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            oldland_dbus_sram #(
                .BASE_ADDR  (c_BASE),
                .ADDR_BITS  (10),
                .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .d_access (acc[g]),
                .d_addr   (addr[g]),
                .d_wr_en  (wen[g]),
                .d_bytesel(bs[g]),
                .d_wr_val (wval[g]),
                .d_data   (rdata[g]),
                .d_ack    (ack[g]),
                .d_error  (err[g])
            );
        end
    endgenerate

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int          k;
        bit          err;
        logic [31:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (ack[k] || err[k]) begin
                    check("ack_err_exclusive", {31'd0, ack[k] & err[k]}, 32'd0);
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_response: dut %0d ack=%b err=%b, expected no response",
                                 k, ack[k], err[k]);
                    end else begin
                        e = sb.pop_front();
                        check("resp_dut",     32'(k),              32'(e.k));
                        check("resp_error",   {31'd0, err[k]},     {31'd0, e.err});
                        check("resp_ack",     {31'd0, ack[k]},     {31'd0, !e.err});
                        check("resp_data",    rdata[k],            e.data);
                        check("resp_latency", 32'(cyc - e.acc_cyc), 32'(ws_of(k) + 2));
                    end
                end
            end
        end
    end

    // One bus transaction. Drives at a falling edge so the next rising edge is
    // the acceptance edge; drops d_access in the response cycle. With perturb
    // set, inputs are scrambled and d_access dropped during the wait period.
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] v, input bit e_err, input logic [31:0] e_data,
                       input bit perturb = 1'b0);
        int   n;
        exp_t x;
        @(negedge clk);
        addr[k] = a;
        wen[k]  = w;
        bs[k]   = b;
        wval[k] = v;
        acc[k]  = 1'b1;
        x.k       = k;
        x.err     = e_err;
        x.data    = e_data;
        x.acc_cyc = cyc + 1;
        sb.push_back(x);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (perturb && n == 2) begin
                acc[k]  = 1'b0;
                addr[k] = a + 32'h4;
                wval[k] = ~v;
                bs[k]   = 4'hF;
            end
        end while (!(ack[k] || err[k]) && n < 40);
        if (!(ack[k] || err[k])) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: dut %0d no response within %0d cycles, expected one", k, n);
            void'(sb.pop_back());
        end
        acc[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            acc[k]  = 1'b0;
            wen[k]  = 1'b0;
            addr[k] = 32'd0;
            bs[k]   = 4'd0;
            wval[k] = 32'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ack",  {31'd0, ack[k]}, 32'd0);
            check("reset_err",  {31'd0, err[k]}, 32'd0);
            check("reset_data", rdata[k],        32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;

        // WAIT_STATES = 1: basic word write/read
        txn(0, 1, c_BASE + 32'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0);
        txn(0, 0, c_BASE + 32'h10, 4'hF, 32'h0,        0, 32'hDEADBEEF);
        // Byte/half merge
        txn(0, 1, c_BASE,          4'hF, 32'h11223344, 0, 32'h0);
        txn(0, 1, c_BASE,          4'h4, 32'h00AA0000, 0, 32'h0);
        txn(0, 1, c_BASE,          4'h3, 32'h00005566, 0, 32'h0);
        txn(0, 0, c_BASE,          4'hF, 32'h0,        0, 32'h11AA5566);
        // Errors: past top of window, illegal lanes, below window, no lanes
        txn(0, 0, c_BASE + 32'h1000, 4'hF, 32'h0,        1, 32'h0);
        txn(0, 1, c_BASE,            4'h5, 32'hFFFFFFFF, 1, 32'h0);
        txn(0, 0, c_BASE,            4'hF, 32'h0,        0, 32'h11AA5566);
        txn(0, 0, c_BASE - 32'h4,    4'hF, 32'h0,        1, 32'h0);
        txn(0, 0, c_BASE + 32'h10,   4'h0, 32'h0,        1, 32'h0);
        // Top word of window and single high byte
        txn(0, 1, c_BASE + 32'hFFC, 4'hF, 32'hCAFEF00D, 0, 32'h0);
        txn(0, 0, c_BASE + 32'hFFC, 4'hF, 32'h0,        0, 32'hCAFEF00D);
        txn(0, 1, c_BASE + 32'h10,  4'h8, 32'h77000000, 0, 32'h0);
        txn(0, 0, c_BASE + 32'h10,  4'hF, 32'h0,        0, 32'h77ADBEEF);
        // Input stability during WAIT
        txn(0, 1, c_BASE + 32'h24, 4'hF, 32'h00000000, 0, 32'h0);
        txn(0, 1, c_BASE + 32'h20, 4'hF, 32'h12345678, 0, 32'h0, 1'b1);
        txn(0, 0, c_BASE + 32'h20, 4'hF, 32'h0,        0, 32'h12345678);
        txn(0, 0, c_BASE + 32'h24, 4'hF, 32'h0,        0, 32'h00000000);

        // WAIT_STATES = 0: back-to-back
        txn(1, 1, c_BASE, 4'hF, 32'hA5A5A5A5, 0, 32'h0);
        for (int i = 0; i < 3; i++) txn(1, 0, c_BASE, 4'hF, 32'h0, 0, 32'hA5A5A5A5);
        txn(1, 1, c_BASE, 4'h2, 32'h00003C00, 0, 32'h0);
        txn(1, 0, c_BASE, 4'hF, 32'h0,        0, 32'hA5A53CA5);
        txn(1, 0, c_BASE + 32'h1000, 4'hF, 32'h0, 1, 32'h0);

        // WAIT_STATES = 3: back-to-back
        txn(2, 1, c_BASE + 32'h8, 4'hF, 32'h0BADCAFE, 0, 32'h0);
        for (int i = 0; i < 3; i++) txn(2, 0, c_BASE + 32'h8, 4'hF, 32'h0, 0, 32'h0BADCAFE);

        // Async reset during WAIT of a write abandons it
        @(negedge clk);
        addr[2] = c_BASE + 32'h8;
        wen[2]  = 1'b1;
        bs[2]   = 4'hF;
        wval[2] = 32'hFFFFFFFF;
        acc[2]  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        acc[2] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_ack",  {31'd0, ack[2]}, 32'd0);
        check("rst_mid_err",  {31'd0, err[2]}, 32'd0);
        check("rst_mid_data", rdata[2],        32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        txn(2, 0, c_BASE + 32'h8, 4'hF, 32'h0, 0, 32'h0BADCAFE);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
